pla_and_programmer: RTL and testbench
=====================================

# pla_and_programmer

Programmable synchronous AND-plane for the Chapter 8 PLA models: the loading (writer) end of the PLA personality interface. A bit-serial programming port loads a 3-row × 8-bit AND-array personality into internal registers. The block then evaluates the three product terms of inputs in0..in7 with registered outputs. It replaces file-based personality loading for synthesizable targets and drives the same out0..out2 function set.

## Interface
- none (fixed geometry: 8 inputs, 3 product rows, 24 personality bits)

- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high; clears all state
- prog_start  input  1  one-cycle pulse; begins (or restarts) personality load
- prog_valid  input  1  prog_bit is valid this cycle (LOAD state only)
- prog_bit  input  1  serial personality bit
- in0..in7  input  1 each  PLA data inputs
- prog_done  output  1  high while in RUN (personality loaded, outputs live)
- out0, out1, out2  output  1 each  registered product-term outputs

## Operation
- Personality: mask[r][i], r = 0..2 (row = output index), i = 0..7 (input index). Bit 1: in_i participates in the AND of row r. Bit 0: in_i is ignored.
- Product term: out_r = AND over all i with mask[r][i]=1 of in_i. An all-zero row yields constant 1.
- Load order: row 0 first, then row 1, then row 2. Within a row, in0 bit first through in7 bit last. Serial bit k (0..23) → mask[k/8][k%8].
- Bit counter: 5 bits, range 0..23, cleared on reset and on prog_start.
- States:
  - IDLE (reset state): outputs 0, prog_done 0. prog_start → LOAD. prog_valid is ignored.
  - LOAD: on each cycle with prog_valid=1, write prog_bit to the addressed mask bit and increment the counter. On the cycle that accepts bit 23 → RUN. prog_start → restart: counter=0, stay in LOAD. Mask bits already written remain until overwritten.
  - RUN: prog_done=1. Each clock, out_r ← product term of the current in0..in7. prog_valid is ignored. prog_start → LOAD and clears the counter.
- Simultaneous prog_start and prog_valid (any state): prog_start wins, and that cycle's prog_bit is discarded.
- On any transition out of RUN: out0..out2 are cleared to 0 at the same edge, and prog_done falls at that edge.
- prog_valid=0 in LOAD: hold the counter and masks; there is no timeout.

## Timing
- Reset (asynchronous assert): state=IDLE, counter=0, all 24 mask bits=0, out0..out2=0, prog_done=0. Deassertion is synchronous to clock by system convention. Reset asserted mid-LOAD or mid-RUN takes effect immediately, and the partial personality is lost.
- Load latency: minimum 1 cycle (prog_start) + 24 prog_valid cycles. prog_done rises at the edge that accepts bit 23.
- Output latency in RUN: 1 clock. Inputs sampled at edge n appear on out_r after edge n.
  - The first valid output follows the edge after prog_done rises. At the bit-23 edge itself, outputs are still 0.
- Combinational paths: none from inputs to outputs. All outputs come straight from flops.
- Gaps between prog_valid pulses are allowed and do not affect the result.

## Test plan
- Reset: assert reset mid-LOAD after 10 bits → out0..out2=0 and prog_done=0 immediately. Then a full load plus input 8'hFF gives outputs consistent only with the new personality.
- Basic load and evaluate: load row0=in0,in1 (bits 1,1,0,0,0,0,0,0), row1=all ones, row2=all zeros.
  - prog_done rises on the 24th bit.
  - Apply in0..in7 = 1,1,0,0,0,0,0,0 → next cycle out0=1, out1=0, out2=1.
  - Apply all ones → out0=1, out1=1, out2=1.
  - Apply all zeros → out0=0, out1=0, out2=1.
- Gapped load: the same personality with prog_valid low for 3 cycles after bits 5 and 17 → identical results to the basic load. prog_done stays 0 until bit 23.
- Restart mid-load: after 12 bits, pulse prog_start with prog_valid=1 and prog_bit=1 → that bit is discarded and the counter is 0. A subsequent 24-bit load of row0=in7 only (bit 7 set) gives out0 = registered in7.
- Reprogram from RUN: in RUN with out1=1, pulse prog_start → outputs are 0 and prog_done is 0 at the next edge. prog_valid pulses in IDLE or RUN change no mask bit (verified by reloading and checking the outputs).
- Latency check: toggle in0 each cycle in RUN with row0=in0 only → out0 follows in0 delayed by exactly 1 clock, with no combinational glitch path.

Source files
------------

// File: rtl/pla_and_programmer_if.sv
// Programming port, PLA data inputs and registered product-term outputs
// of the programmable AND-plane.
interface pla_and_programmer_if;
  logic prog_start;
  logic prog_valid;
  logic prog_bit;
  logic in0, in1, in2, in3, in4, in5, in6, in7;
  logic prog_done;
  logic out0, out1, out2;

  modport master (
    output prog_start, prog_valid, prog_bit,
    output in0, in1, in2, in3, in4, in5, in6, in7,
    input  prog_done, out0, out1, out2
  );

  modport slave (
    input  prog_start, prog_valid, prog_bit,
    input  in0, in1, in2, in3, in4, in5, in6, in7,
    output prog_done, out0, out1, out2
  );
endinterface

// File: rtl/pla_and_programmer.sv
// Bit-serial loadable 3x8 AND-plane; evaluates three product terms of
// in0..in7 into registered outputs once the 24-bit personality is loaded.
module pla_and_programmer (
  input logic clk,
  input logic rst,
  pla_and_programmer_if.slave bus
);
  // state | meaning
  // IDLE  | after reset, waiting for prog_start, outputs held 0
  // LOAD  | shifting personality bits into mask, one per prog_valid
  // RUN   | personality complete, outputs track product terms
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [23:0] mask;
  logic [7:0]  in_vec;
  logic [2:0]  term;
  logic [2:0]  out_q;
  logic        done_q;

  assign in_vec = {bus.in7, bus.in6, bus.in5, bus.in4,
                   bus.in3, bus.in2, bus.in1, bus.in0};

  // Masked-off inputs are forced to 1, so an all-zero row evaluates to 1.
  always_comb begin
    term = '0;
    for (int r = 0; r < 3; r++) begin
      term[r] = &(in_vec | ~mask[8*r +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      mask    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.prog_start) begin
            state   <= LOAD;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          if (bus.prog_start) begin
            bit_cnt <= '0;
          end else if (bus.prog_valid) begin
            mask[bit_cnt] <= bus.prog_bit;
            if (bit_cnt == 5'd23) begin
              state   <= RUN;
              bit_cnt <= '0;
              done_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        RUN: begin
          if (bus.prog_start) begin
            state   <= LOAD;
            bit_cnt <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
          end else begin
            out_q <= term;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          out_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_done = done_q;
  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
endmodule

// File: tb/tb_pla_and_programmer.sv
// Directed, table-driven bench for pla_and_programmer with hand-computed
// expectations plus sequences for gapped, restarted and reset loads.
module tb_pla_and_programmer;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  pla_and_programmer_if bus ();

  pla_and_programmer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         pers;
    logic [7:0] in_val;
    logic [2:0] exp_out;
  } vec_t;

  // {row2, row1, row0}; bit k of the vector is serial bit k
  localparam logic [23:0] P_BASIC = 24'h00FF03;
  localparam logic [23:0] P_ALT   = 24'h0F8180;
  localparam logic [23:0] P_IN7   = 24'h000080;
  localparam logic [23:0] P_IN0   = 24'h000001;

  logic [23:0] p_tab [2];
  vec_t        vt [11];

  function automatic logic [3:0] obs();
    return {bus.prog_done, bus.out2, bus.out1, bus.out0};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got done/out=%b expected %b", nm, act, exp);
  endtask

  task automatic set_in(input logic [7:0] v);
    {bus.in7, bus.in6, bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0} = v;
  endtask

  // Starts and ends at a negedge.
  task automatic apply_chk(input string nm, input logic [7:0] v, input logic [2:0] exp);
    set_in(v);
    @(posedge clk); #1;
    chk(nm, obs(), {1'b1, exp});
    @(negedge clk);
  endtask

  // prog_start cycle (optionally with a prog_valid that must be discarded),
  // then 24 bits with optional 3-cycle gaps after bits gap_a and gap_b.
  task automatic load(input logic [23:0] p, input int gap_a, input int gap_b,
                      input logic start_valid);
    bus.prog_start = 1'b1;
    bus.prog_valid = start_valid;
    bus.prog_bit   = 1'b1;
    @(negedge clk);
    bus.prog_start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      bus.prog_valid = 1'b1;
      bus.prog_bit   = p[k];
      @(posedge clk); #1;
      chk("load_bit", obs(), {(k == 23), 3'b000});
      @(negedge clk);
      bus.prog_valid = 1'b0;
      bus.prog_bit   = 1'b0;
      if (k == gap_a || k == gap_b) begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("load_gap", obs(), 4'b0000);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic partial(input int n);
    bus.prog_start = 1'b1;
    @(negedge clk);
    bus.prog_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.prog_valid = 1'b1;
      bus.prog_bit   = 1'b1;
      @(negedge clk);
    end
    bus.prog_valid = 1'b0;
    bus.prog_bit   = 1'b0;
  endtask

  initial begin
    logic [2:0] prev;
    int cur;
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.prog_start = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_bit   = 1'b0;
    set_in(8'h00);

    p_tab[0] = P_BASIC;
    p_tab[1] = P_ALT;
    vt[0]  = '{0, 8'h03, 3'b101};
    vt[1]  = '{0, 8'hFF, 3'b111};
    vt[2]  = '{0, 8'h00, 3'b100};
    vt[3]  = '{0, 8'h01, 3'b100};
    vt[4]  = '{0, 8'hFE, 3'b100};
    vt[5]  = '{0, 8'h07, 3'b101};
    vt[6]  = '{1, 8'h80, 3'b001};
    vt[7]  = '{1, 8'h81, 3'b011};
    vt[8]  = '{1, 8'h0F, 3'b100};
    vt[9]  = '{1, 8'h8F, 3'b111};
    vt[10] = '{1, 8'h00, 3'b000};

    repeat (2) @(negedge clk);
    chk("reset_state", obs(), 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    cur = -1;
    for (int i = 0; i < 11; i++) begin
      if (vt[i].pers != cur) begin
        load(p_tab[vt[i].pers], -1, -1, 1'b0);
        cur = vt[i].pers;
      end
      apply_chk("table_vec", vt[i].in_val, vt[i].exp_out);
    end

    load(P_BASIC, 5, 17, 1'b0);
    apply_chk("gapped_03", 8'h03, 3'b101);
    apply_chk("gapped_ff", 8'hFF, 3'b111);
    apply_chk("gapped_00", 8'h00, 3'b100);

    // prog_valid in RUN must not touch the mask (row2 would go all-ones)
    set_in(8'h03);
    bus.prog_valid = 1'b1;
    bus.prog_bit   = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      chk("run_ignores_valid", obs(), 4'b1101);
    end
    @(negedge clk);
    bus.prog_valid = 1'b0;
    bus.prog_bit   = 1'b0;

    apply_chk("run_out1_high", 8'hFF, 3'b111);
    bus.prog_start = 1'b1;
    bus.prog_valid = 1'b1;
    bus.prog_bit   = 1'b1;
    @(posedge clk); #1;
    chk("reprog_from_run", obs(), 4'b0000);
    @(negedge clk);
    bus.prog_start = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_bit   = 1'b0;

    partial(12);
    load(P_IN7, -1, -1, 1'b1);
    apply_chk("restart_in7_hi", 8'h80, 3'b111);
    apply_chk("restart_in7_lo", 8'h7F, 3'b110);
    apply_chk("restart_ff", 8'hFF, 3'b111);
    apply_chk("restart_00", 8'h00, 3'b110);

    // IDLE ignores prog_valid: counter must still need all 24 bits afterwards
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.prog_valid = 1'b1;
    bus.prog_bit   = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("idle_ignores_valid", obs(), 4'b0000);
    end
    @(negedge clk);
    bus.prog_valid = 1'b0;
    bus.prog_bit   = 1'b0;
    load(P_BASIC, -1, -1, 1'b0);
    apply_chk("after_idle_03", 8'h03, 3'b101);

    load(P_IN0, -1, -1, 1'b0);
    prev = 3'b000;
    for (int i = 0; i < 10; i++) begin
      set_in({7'b0, i[0]});
      #1;
      chk("latency_hold", obs(), {1'b1, prev});
      @(posedge clk); #1;
      prev = {2'b11, i[0]};
      chk("latency_follow", obs(), {1'b1, prev});
      @(negedge clk);
    end

    #2 rst = 1'b1;
    #1 chk("async_reset_run", obs(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    partial(10);
    #2 rst = 1'b1;
    #1 chk("async_reset_load", obs(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(P_BASIC, -1, -1, 1'b0);
    apply_chk("post_reset_ff", 8'hFF, 3'b111);
    apply_chk("post_reset_03", 8'h03, 3'b101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
